// File: rtl/ram_arbiter.sv
// Round-robin arbiter giving two hosts access to one single-port SRAM.
// Read responses go back to the issuing host through an in-order ID FIFO.
module ram_arbiter #(
    parameter int unsigned Aw          = 9,
    parameter int unsigned Dw          = 32,
    parameter int unsigned Outstanding = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [1:0]      req_i,
    input  logic [1:0]      we_i,
    input  logic [2*Aw-1:0] addr_i,
    input  logic [2*Dw-1:0] wdata_i,
    input  logic [2*Dw-1:0] wmask_i,
    output logic [1:0]      gnt_o,
    output logic [1:0]      rvalid_o,
    output logic [Dw-1:0]   rdata_o,
    output logic            ram_req_o,
    output logic            ram_we_o,
    output logic [Aw-1:0]   ram_addr_o,
    output logic [Dw-1:0]   ram_wdata_o,
    output logic [Dw-1:0]   ram_wmask_o,
    input  logic [Dw-1:0]   ram_rdata_i,
    input  logic            ram_rvalid_i,
    output logic            busy_o,
    output logic            err_o
);

    localparam int unsigned PtrW = (Outstanding > 1) ? $clog2(Outstanding) : 1;
    localparam int unsigned CntW = $clog2(Outstanding + 1);

    logic                   last_gnt_q;
    logic [Outstanding-1:0] id_q;
    logic [PtrW-1:0]        wptr_q, rptr_q;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   err_q;

    logic full, empty, cand, sel, push, pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Outstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Full and empty depend only on registered count, so ram_rvalid_i never reaches gnt_o.
    assign full  = (cnt_q == CntW'(Outstanding));
    assign empty = (cnt_q == '0);

    always_comb begin
        cand = req_i[1];
        if (&req_i) begin
            cand = ~last_gnt_q;
        end
    end

    // Reset gating keeps grants off while the whole subsystem is held in reset.
    always_comb begin
        gnt_o = 2'b00;
        if (|req_i && !full && rst_ni) begin
            gnt_o = cand ? 2'b10 : 2'b01;
        end
    end

    assign sel         = gnt_o[1];
    assign ram_req_o   = |gnt_o;
    assign ram_we_o    = sel ? we_i[1] : we_i[0];
    assign ram_addr_o  = sel ? addr_i[Aw +: Aw] : addr_i[0 +: Aw];
    assign ram_wdata_o = sel ? wdata_i[Dw +: Dw] : wdata_i[0 +: Dw];
    assign ram_wmask_o = sel ? wmask_i[Dw +: Dw] : wmask_i[0 +: Dw];

    assign push = ram_req_o & ~ram_we_o;
    assign pop  = ram_rvalid_i & ~empty;

    always_comb begin
        rvalid_o = 2'b00;
        if (pop) begin
            rvalid_o = id_q[rptr_q] ? 2'b10 : 2'b01;
        end
    end

    assign rdata_o = ram_rdata_i;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_gnt_q <= 1'b1;
            id_q       <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            if (ram_req_o) begin
                last_gnt_q <= sel;
            end
            if (push) begin
                id_q[wptr_q] <= sel;
                wptr_q       <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            cnt_q <= cnt_d;
            if (ram_rvalid_i && empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign busy_o = ~empty;
    assign err_o  = err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural SRAM of selectable read latency.
module tb_ram_arbiter;

    localparam int unsigned Aw          = 9;
    localparam int unsigned Dw          = 32;
    localparam int unsigned Outstanding = 2;

    localparam logic [1:0] BpGnt [8] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    localparam logic [1:0] BpRv  [8] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01};

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [1:0]      req_i, we_i;
    logic [2*Aw-1:0] addr_i;
    logic [2*Dw-1:0] wdata_i, wmask_i;
    logic [1:0]      gnt_o, rvalid_o;
    logic [Dw-1:0]   rdata_o;
    logic            ram_req_o, ram_we_o;
    logic [Aw-1:0]   ram_addr_o;
    logic [Dw-1:0]   ram_wdata_o, ram_wmask_o, ram_rdata_i;
    logic            ram_rvalid_i;
    logic            busy_o, err_o;

    int   errors = 0;
    int   checks = 0;
    int   lat    = 1;
    logic spur   = 1'b0;

    always #5 clk_i = ~clk_i;

    ram_arbiter #(
        .Aw(Aw), .Dw(Dw), .Outstanding(Outstanding)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .wmask_i(wmask_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .ram_req_o(ram_req_o), .ram_we_o(ram_we_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_wmask_o(ram_wmask_o),
        .ram_rdata_i(ram_rdata_i), .ram_rvalid_i(ram_rvalid_i), .busy_o(busy_o), .err_o(err_o)
    );

    // SRAM model: word i holds 0x1000_0000|i, except word 0x10 which starts at zero.
    logic [Dw-1:0] mem [512];
    logic [3:1]    pv;
    logic [Dw-1:0] pd [1:3];

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 512; i++) begin
                mem[i] <= (i == 16) ? 32'h0 : (32'h1000_0000 | 32'(i));
            end
            pv <= '0;
            for (int i = 1; i <= 3; i++) pd[i] <= '0;
        end else begin
            pv    <= {pv[2:1], ram_req_o & ~ram_we_o};
            pd[1] <= mem[ram_addr_o];
            pd[2] <= pd[1];
            pd[3] <= pd[2];
            if (ram_req_o && ram_we_o) begin
                mem[ram_addr_o] <= (mem[ram_addr_o] & ~ram_wmask_o) | (ram_wdata_o & ram_wmask_o);
            end
        end
    end

    assign ram_rvalid_i = pv[lat] | spur;
    assign ram_rdata_i  = pd[lat];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni  = 1'b0;
        req_i   = 2'b11;
        we_i    = 2'b00;
        addr_i  = {9'h021, 9'h020};
        wdata_i = '0;
        wmask_i = '0;

        repeat (2) @(negedge clk_i);
        #1;
        check("rst_gnt", 32'(gnt_o), 32'h0);
        check("rst_ram_req", 32'(ram_req_o), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_rvalid", 32'(rvalid_o), 32'h0);

        // Contention: both hosts read, grants alternate starting with host 0.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            if (k == 0) rst_ni = 1'b1;
            #1;
            check("cont_gnt", 32'(gnt_o), (k % 2 == 1) ? 32'h2 : 32'h1);
            if (k == 0) begin
                check("cont_rv0", 32'(rvalid_o), 32'h0);
            end else begin
                check("cont_rv", 32'(rvalid_o), (k % 2 == 1) ? 32'h1 : 32'h2);
                check("cont_rdata", rdata_o, (k % 2 == 1) ? 32'h1000_0020 : 32'h1000_0021);
                check("cont_busy", 32'(busy_o), 32'h1);
            end
        end
        @(negedge clk_i);
        req_i = 2'b00;
        #1;
        check("cont_tail_gnt", 32'(gnt_o), 32'h0);
        check("cont_tail_rv", 32'(rvalid_o), 32'h2);
        check("cont_tail_rdata", rdata_o, 32'h1000_0021);
        @(negedge clk_i);
        #1;
        check("cont_idle_busy", 32'(busy_o), 32'h0);
        check("cont_idle_rv", 32'(rvalid_o), 32'h0);

        // Mixed: host 0 masked write, host 1 read of the same word.
        @(negedge clk_i);
        req_i   = 2'b11;
        we_i    = 2'b01;
        addr_i  = {9'h010, 9'h010};
        wdata_i = {32'h0, 32'hDEAD_BEEF};
        wmask_i = {32'h0, 32'hFFFF_00FF};
        #1;
        check("mix_gnt0", 32'(gnt_o), 32'h1);
        check("mix_we", 32'(ram_we_o), 32'h1);
        check("mix_addr", 32'(ram_addr_o), 32'h10);
        check("mix_wdata", ram_wdata_o, 32'hDEAD_BEEF);
        check("mix_wmask", ram_wmask_o, 32'hFFFF_00FF);
        @(negedge clk_i);
        req_i = 2'b10;
        we_i  = 2'b00;
        #1;
        check("mix_gnt1", 32'(gnt_o), 32'h2);
        check("mix_rd_we", 32'(ram_we_o), 32'h0);
        check("mix_no_wr_rv", 32'(rvalid_o), 32'h0);
        @(negedge clk_i);
        req_i = 2'b00;
        #1;
        check("mix_rv", 32'(rvalid_o), 32'h2);
        check("mix_rdata", rdata_o, 32'hDEAD_00EF);

        // Single host 1 streaming reads.
        @(negedge clk_i);
        req_i  = 2'b10;
        addr_i = {9'h022, 9'h030};
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk_i);
            #1;
            check("single_gnt", 32'(gnt_o), 32'h2);
            check("single_rv", 32'(rvalid_o), (k == 0) ? 32'h0 : 32'h2);
        end
        @(negedge clk_i);
        req_i = 2'b00;
        #1;
        check("single_tail_rv", 32'(rvalid_o), 32'h2);
        check("single_rdata", rdata_o, 32'h1000_0022);
        repeat (3) @(negedge clk_i);

        // Backpressure: 3-cycle RAM, host 0 streams reads into a 2-deep FIFO.
        lat   = 3;
        req_i = 2'b01;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk_i);
            #1;
            check("bp_gnt", 32'(gnt_o), 32'(BpGnt[k]));
            check("bp_rv", 32'(rvalid_o), 32'(BpRv[k]));
            if (k > 0) check("bp_busy", 32'(busy_o), 32'h1);
            if (BpRv[k] != 2'b00) check("bp_rdata", rdata_o, 32'h1000_0030);
        end
        @(negedge clk_i);
        req_i = 2'b00;
        #1;
        check("bp_drain_rv", 32'(rvalid_o), 32'h1);
        check("bp_drain_gnt", 32'(gnt_o), 32'h0);
        @(negedge clk_i);
        #1;
        check("bp_idle_busy", 32'(busy_o), 32'h0);
        check("bp_idle_rv", 32'(rvalid_o), 32'h0);

        // Spurious response with empty FIFO.
        @(negedge clk_i);
        lat  = 1;
        spur = 1'b1;
        #1;
        check("spur_rv", 32'(rvalid_o), 32'h0);
        check("spur_err_pre", 32'(err_o), 32'h0);
        @(negedge clk_i);
        spur = 1'b0;
        #1;
        check("spur_err", 32'(err_o), 32'h1);
        check("spur_busy", 32'(busy_o), 32'h0);
        @(negedge clk_i);
        req_i = 2'b01;
        #1;
        check("spur_gnt", 32'(gnt_o), 32'h1);
        @(negedge clk_i);
        req_i = 2'b00;
        #1;
        check("spur_after_rv", 32'(rvalid_o), 32'h1);
        check("spur_after_rdata", rdata_o, 32'h1000_0030);
        check("spur_err_hold", 32'(err_o), 32'h1);

        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("reset_err_clr", 32'(err_o), 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
